// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM, queues
// {PC, word} pairs in a small FIFO and hands them to decode over valid/ready.
// Redirects from execute flush the FIFO and restart fetch at the new PC.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 7'd4,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [ADDR_W-1:0] mem_pc_q    [DEPTH];
  logic [DATA_W-1:0] mem_instr_q [DEPTH];

  logic push;
  logic pop;

  // Redirect targets are forced to word alignment, so the low bits never matter.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ROM enable is purely a function of state, occupancy and redirect; decode's
  // ready never reaches the ROM so the fetch path stays short.
  assign rom_en   = (state_q == RUN) && (count_q < FULL_CNT) && !redirect_valid;
  assign rom_addr = pc_q;
  assign push     = rom_en;
  assign pop      = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q]    : '0;

  // Next-state logic: start/halt control; a redirect never blocks the transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt)  state_d = HALT;
      HALT:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // PC and FIFO bookkeeping; a redirect overrides fetch and pop in the same cycle.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are only observed through count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= rom_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic [6:0]  rom_addr;
  logic        rom_en;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [6:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [6:0]  out_pc;

  logic [31:0] rom [32];

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_W(7), .DATA_W(32), .RESET_PC(7'd4), .DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  assign rom_data = rom_en ? rom[rom_addr[6:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s, h, r, d;
    logic [6:0] rpc;
    logic       en;
    logic [6:0] addr;
    logic       vld;
    logic [6:0] opc;
  } vec_t;

  vec_t tbl[28];
  int   nrows = 0;

  typedef struct {
    int          pc;
    logic [31:0] w;
  } ent_t;

  ent_t q[$];
  int   mode;   // 0 idle, 1 run, 2 halt
  int   mpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic row(input int s, input int h, input int r, input int d, input int rp,
                     input int en, input int a, input int v, input int op);
    tbl[nrows].s    = s[0];
    tbl[nrows].h    = h[0];
    tbl[nrows].r    = r[0];
    tbl[nrows].d    = d[0];
    tbl[nrows].rpc  = 7'(rp);
    tbl[nrows].en   = en[0];
    tbl[nrows].addr = 7'(a);
    tbl[nrows].vld  = v[0];
    tbl[nrows].opc  = 7'(op);
    nrows++;
  endtask

  task automatic drive(input logic s, input logic h, input logic r, input logic d,
                       input logic [6:0] rp);
    @(negedge clk);
    start          = s;
    halt           = h;
    out_ready      = r;
    redirect_valid = d;
    redirect_pc    = rp;
    #1;
  endtask

  // One randomized cycle: compare DUT against the model, then advance the model.
  task automatic rstep();
    logic s, h, r, d;
    logic [6:0] rp;
    logic exp_en;
    s  = ($urandom % 6) == 0;
    h  = ($urandom % 12) == 0;
    r  = ($urandom % 3) != 0;
    d  = ($urandom % 10) == 0;
    rp = 7'($urandom % 128);
    drive(s, h, r, d, rp);
    exp_en = (mode == 1) && (q.size() < 2) && !d;
    chk("rnd_rom_en", 32'(rom_en), 32'(exp_en));
    chk("rnd_rom_addr", 32'(rom_addr), 32'(mpc));
    chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("rnd_out_pc", 32'(out_pc), (q.size() > 0) ? 32'(q[0].pc) : 32'h0);
    chk("rnd_out_instr", out_instr, (q.size() > 0) ? q[0].w : 32'h0);
    if (d) begin
      mpc = (int'(rp) / 4) * 4;
      q.delete();
    end else begin
      if (q.size() > 0 && r) void'(q.pop_front());
      if (exp_en) begin
        q.push_back('{pc: mpc, w: rom[mpc / 4]});
        mpc = (mpc + 4) % 128;
      end
    end
    if (mode == 0 && s) mode = 1;
    else if (mode == 1 && h) mode = 2;
    else if (mode == 2 && s) mode = 1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 + 32'(i * 4);
    start = 1'b0; halt = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 7'd0;
    rst_n = 1'b0;
    #12;
    chk("reset_rom_en", 32'(rom_en), 32'h0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd4);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_out_pc", 32'(out_pc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // s h r d rpc | en addr vld opc
    row(0,0,0,0,0,   0,4,0,0);
    row(1,0,1,0,0,   0,4,0,0);
    row(0,0,1,0,0,   1,4,0,0);
    row(0,0,1,0,0,   1,8,1,4);
    row(0,0,1,0,0,   1,12,1,8);
    row(0,0,1,0,0,   1,16,1,12);
    row(0,0,0,0,0,   1,20,1,16);
    row(0,0,0,0,0,   0,24,1,16);
    row(0,0,0,0,0,   0,24,1,16);
    row(0,0,1,0,0,   0,24,1,16);
    row(0,0,1,0,0,   1,24,1,20);
    row(0,0,1,1,10,  0,28,1,24);
    row(0,0,1,0,0,   1,8,0,0);
    row(0,0,1,0,0,   1,12,1,8);
    row(0,0,1,1,124, 0,16,1,12);
    row(0,0,1,0,0,   1,124,0,0);
    row(0,0,1,0,0,   1,0,1,124);
    row(0,0,1,0,0,   1,4,1,0);
    row(0,1,1,0,0,   1,8,1,4);
    row(0,0,0,0,0,   0,12,1,8);
    row(0,0,1,0,0,   0,12,1,8);
    row(1,0,1,0,0,   0,12,0,0);
    row(0,0,1,0,0,   1,12,0,0);
    row(1,1,1,0,0,   1,16,1,12);
    row(0,0,1,0,0,   0,20,1,16);
    row(0,0,1,0,0,   0,20,0,0);
    row(0,0,1,1,40,  0,20,0,0);
    row(0,0,1,0,0,   0,40,0,0);

    for (int i = 0; i < nrows; i++) begin
      drive(tbl[i].s, tbl[i].h, tbl[i].r, tbl[i].d, tbl[i].rpc);
      chk($sformatf("row%0d_rom_en", i), 32'(rom_en), 32'(tbl[i].en));
      chk($sformatf("row%0d_rom_addr", i), 32'(rom_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d_out_pc", i), 32'(out_pc), 32'(tbl[i].opc));
      chk($sformatf("row%0d_out_instr", i), out_instr,
          tbl[i].vld ? rom[tbl[i].opc[6:2]] : 32'h0);
    end

    // Fill both entries from HALT at PC 40, then reset asynchronously mid-cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    chk("full_rom_en", 32'(rom_en), 32'h0);
    chk("full_rom_addr", 32'(rom_addr), 32'd48);
    chk("full_out_pc", 32'(out_pc), 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_rom_addr", 32'(rom_addr), 32'd4);
    chk("async_rom_en", 32'(rom_en), 32'h0);
    chk("async_out_pc", 32'(out_pc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    chk("post_reset_idle_rom_en", 32'(rom_en), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
    chk("post_reset_start_rom_en", 32'(rom_en), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    chk("post_reset_fetch_en", 32'(rom_en), 32'h1);
    chk("post_reset_fetch_addr", 32'(rom_addr), 32'd4);

    // Randomized phase against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    mode = 0;
    mpc  = 4;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) rstep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
